// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Row/column counts, FSM state encoding, row reset pattern, column picker.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    localparam logic [NUM_ROWS-1:0] ROW_RST = 4'b1110;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    // Lowest-index closed (low) column wins.
    function automatic logic [1:0] low_zero(
        input logic [NUM_COLS-1:0] c
    );
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!c[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pin/result bundle.
// master: scanner side; slave: keypad + consumer side.
interface keypad_scan_if;
    import keypad_pkg::*;

    logic [NUM_COLS-1:0] col_in;
    logic [NUM_ROWS-1:0] row_out;
    logic [3:0]          key_code;
    logic                key_valid;
    logic                key_pressed;

    modport master (
        input  col_in,
        output row_out,
        output key_code,
        output key_valid,
        output key_pressed
    );

    modport slave (
        output col_in,
        input  row_out,
        input  key_code,
        input  key_valid,
        input  key_pressed
    );

endinterface

// File: rtl/keypad_scan_tick.sv
// Free-running scan divider: tick pulses one clk every 2^DIV_W clks.
// Ports: clk, reset (async active-low), tick (out).
module scan_tick #(
    parameter int DIV_W = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [DIV_W-1:0] div_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) div_q <= '0;
        else        div_q <= div_q + DIV_W'(1);
    end

    assign tick = &div_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with debounce; emits key code, valid strobe, pressed.
// Ports: clk, reset (async active-low), kp (keypad_scan_if.master).
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int DIV_W          = 16,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic          clk,
    input  logic          reset,
    keypad_scan_if.master kp
);

    localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic tick;

    scan_tick #(
        .DIV_W(DIV_W)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // col_in is asynchronous; only col_s is used downstream.
    logic [NUM_COLS-1:0] sync_a;
    logic [NUM_COLS-1:0] col_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '1;
            col_s  <= '1;
        end else begin
            sync_a <= kp.col_in;
            col_s  <= sync_a;
        end
    end

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          row_q, row_d;
    logic [1:0]          cap_q, cap_d;
    logic [NUM_ROWS-1:0] rows_q, rows_d;
    logic [3:0]          code_q, code_d;
    logic                valid_q, valid_d;
    logic                pressed_q, pressed_d;

    logic [CW-1:0]       cnt_inc;
    logic [NUM_ROWS-1:0] rows_rot;

    assign cnt_inc  = cnt_q + CW'(1);
    assign rows_rot = {rows_q[NUM_ROWS-2:0], rows_q[NUM_ROWS-1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        cap_d     = cap_q;
        rows_d    = rows_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        pressed_d = pressed_q;
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (col_s == '1) begin
                        row_d  = row_q + 2'd1;
                        rows_d = rows_rot;
                    end else begin
                        cap_d   = low_zero(col_s);
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!col_s[cap_q]) begin
                        if (cnt_inc == CNT_LAST) begin
                            code_d    = {row_q, cap_q};
                            valid_d   = 1'b1;
                            pressed_d = 1'b1;
                            cnt_d     = '0;
                            state_d   = HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        row_d   = row_q + 2'd1;
                        rows_d  = rows_rot;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (col_s[cap_q]) begin
                        if (cnt_inc == CNT_LAST) begin
                            pressed_d = 1'b0;
                            cnt_d     = '0;
                            row_d     = row_q + 2'd1;
                            rows_d    = rows_rot;
                            state_d   = SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // a release needs consecutive open ticks
                        cnt_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SCAN;
            cnt_q     <= '0;
            row_q     <= 2'd0;
            cap_q     <= 2'd0;
            rows_q    <= ROW_RST;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            cap_q     <= cap_d;
            rows_q    <= rows_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
        end
    end

    assign kp.row_out     = rows_q;
    assign kp.key_code    = code_q;
    assign kp.key_valid   = valid_q;
    assign kp.key_pressed = pressed_q;

endmodule
